controlador_varredura: RTL

//  Scan sequencer for the 4-digit multiplexed 7-seg display: generates the 2-bit digit

---
 rtl/controlador_varredura.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/controlador_varredura.sv
// Scan sequencer for a 4-digit multiplexed 7-segment display: digit select, digit
// enable with per-slot dead time, once-per-frame digit latching and leading-zero blanking.
module controlador_varredura #(
   parameter int DIV_VARREDURA = 50000,
   parameter int BLANK_CICLOS  = 500
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       habilitar,
   input  logic       zeros_esq,
   input  logic [3:0] duzias_dezenas_in,
   input  logic [3:0] duzias_unidades_in,
   input  logic [3:0] rolhas_dezenas_in,
   input  logic [3:0] rolhas_unidades_in,
   output logic [1:0] contador,
   output logic       ligado,
   output logic [3:0] duzias_dezenas,
   output logic [3:0] duzias_unidades,
   output logic [3:0] rolhas_dezenas,
   output logic [3:0] rolhas_unidades,
   output logic       fim_quadro
);

   localparam int             CW        = $clog2(DIV_VARREDURA);
   localparam int             B_ULT_I   = (BLANK_CICLOS > 32'sd0) ? (BLANK_CICLOS - 32'sd1) : 32'sd0;
   localparam logic [CW-1:0]  D_ULT     = CW'(DIV_VARREDURA - 32'sd1);
   localparam logic [CW-1:0]  B_ULT     = CW'(B_ULT_I);
   localparam logic           SEM_BLANK = (BLANK_CICLOS == 32'sd0);
   localparam logic [CW-1:0]  CNT_ZERO  = {CW{1'b0}};
   localparam logic [CW-1:0]  CNT_UM    = CW'(1'b1);

   typedef enum logic [1:0] {
      DESLIGADO = 2'd0,
      BLANK     = 2'd1,
      ATIVO     = 2'd2
   } estado_t;

   estado_t       state_r, state_n;
   logic [CW-1:0] cnt_r, cnt_n;
   logic [1:0]    contador_r, contador_n;
   logic          ligado_r, ligado_n;
   logic          fim_quadro_r;
   logic          captura_s;
   logic          suprime_s;
   logic [3:0]    dd_r, du_r, rd_r, ru_r;
   logic [3:0]    dd_n, du_n, rd_n, ru_n;

   // A "dezenas" digit showing zero is blanked when leading-zero suppression is requested
   function automatic logic suprimir(input logic       zeros,
                                     input logic [1:0] slot,
                                     input logic [3:0] dezenas_duzias,
                                     input logic [3:0] dezenas_rolhas);
      logic s;
      s = 1'b0;
      if (zeros) begin
         case (slot)
            2'd0:    s = (dezenas_duzias == 4'd0);
            2'd2:    s = (dezenas_rolhas == 4'd0);
            default: s = 1'b0;
         endcase
      end else begin
         s = 1'b0;
      end
      return s;
   endfunction

   // Next-state, slot prescaler and digit-select sequencing
   always_comb begin
      state_n    = state_r;
      cnt_n      = cnt_r;
      contador_n = contador_r;
      captura_s  = 1'b0;
      if (!habilitar) begin
         state_n    = DESLIGADO;
         cnt_n      = CNT_ZERO;
         contador_n = 2'd0;
      end else begin
         case (state_r)
            DESLIGADO: begin
               state_n    = SEM_BLANK ? ATIVO : BLANK;
               cnt_n      = CNT_ZERO;
               contador_n = 2'd0;
               captura_s  = 1'b1;
            end
            BLANK: begin
               cnt_n = cnt_r + CNT_UM;
               if (cnt_r == B_ULT) begin
                  state_n = ATIVO;
               end else begin
                  state_n = BLANK;
               end
            end
            ATIVO: begin
               if (cnt_r == D_ULT) begin
                  cnt_n      = CNT_ZERO;
                  contador_n = contador_r + 2'd1;
                  state_n    = SEM_BLANK ? ATIVO : BLANK;
                  captura_s  = (contador_r == 2'd3);
               end else begin
                  cnt_n   = cnt_r + CNT_UM;
                  state_n = ATIVO;
               end
            end
            default: begin
               state_n    = DESLIGADO;
               cnt_n      = CNT_ZERO;
               contador_n = 2'd0;
            end
         endcase
      end
   end

   // Frame capture and digit-enable decode, using the values valid after the edge
   always_comb begin
      dd_n = dd_r;
      du_n = du_r;
      rd_n = rd_r;
      ru_n = ru_r;
      if (captura_s) begin
         dd_n = duzias_dezenas_in;
         du_n = duzias_unidades_in;
         rd_n = rolhas_dezenas_in;
         ru_n = rolhas_unidades_in;
      end else begin
         dd_n = dd_r;
         du_n = du_r;
         rd_n = rd_r;
         ru_n = ru_r;
      end
      suprime_s = suprimir(zeros_esq, contador_n, dd_n, rd_n);
      ligado_n  = (state_n == ATIVO) && !suprime_s;
   end

   // State and output registers; reset wins over everything
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r      <= DESLIGADO;
         cnt_r        <= CNT_ZERO;
         contador_r   <= 2'd0;
         ligado_r     <= 1'b0;
         fim_quadro_r <= 1'b0;
         dd_r         <= 4'd0;
         du_r         <= 4'd0;
         rd_r         <= 4'd0;
         ru_r         <= 4'd0;
      end else begin
         state_r      <= state_n;
         cnt_r        <= cnt_n;
         contador_r   <= contador_n;
         ligado_r     <= ligado_n;
         fim_quadro_r <= captura_s;
         dd_r         <= dd_n;
         du_r         <= du_n;
         rd_r         <= rd_n;
         ru_r         <= ru_n;
      end
   end

   assign contador        = contador_r;
   assign ligado          = ligado_r;
   assign fim_quadro      = fim_quadro_r;
   assign duzias_dezenas  = dd_r;
   assign duzias_unidades = du_r;
   assign rolhas_dezenas  = rd_r;
   assign rolhas_unidades = ru_r;

endmodule
